// File: rtl/param_compute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : param_compute_unit
//  Description : Two-stage register-file compute unit. An instruction is
//                accepted into S1, then executes against the committed
//                register file while loading a valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module param_compute_unit #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 16,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_W-1:0]  in_tgt,
    input  logic [REG_W-1:0]  in_src0,
    input  logic [REG_W-1:0]  in_src1,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_reg_id,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_illegal,
    output logic [15:0]       retired_cnt
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;

    // S1 instruction holding register
    logic              s1_valid;
    logic [3:0]        s1_op;
    logic [REG_W-1:0]  s1_tgt;
    logic [REG_W-1:0]  s1_src0;
    logic [REG_W-1:0]  s1_src1;
    logic [DATA_W-1:0] s1_imm;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              exec_fire;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [31:0]       shamt;

    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              res_zero;
    logic              res_illegal;
    logic              res_write;
    logic              res_out;

    // S1 executes whenever the output register is empty or being drained
    assign exec_fire = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || exec_fire;

    // Operands always come from the committed register file
    assign op_a     = regs[s1_src0];
    assign op_b     = regs[s1_src1];
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    // Top bit of the extended difference is the unsigned borrow
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
    // DATA_W need not be a power of two, so a true modulo is required
    assign shamt    = 32'(op_b) % 32'(DATA_W);

    // Result, flags and side-effect decode for the instruction in S1
    always_comb begin
        res_data    = '0;
        res_carry   = 1'b0;
        res_zero    = 1'b0;
        res_illegal = 1'b0;
        res_write   = 1'b1;
        res_out     = 1'b1;
        case (s1_op)
            OP_NOP: begin
                res_write = 1'b0;
                res_out   = 1'b0;
            end
            OP_LOAD: res_data = s1_imm;
            OP_ADD: begin
                res_data  = sum_ext[DATA_W-1:0];
                res_carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                res_data  = diff_ext[DATA_W-1:0];
                res_carry = diff_ext[DATA_W];
            end
            OP_AND:  res_data = op_a & op_b;
            OP_OR:   res_data = op_a | op_b;
            OP_NOT:  res_data = ~op_a;
            OP_XOR:  res_data = op_a ^ op_b;
            OP_SHL:  res_data = op_a << shamt;
            OP_SHR:  res_data = op_a >> shamt;
            OP_MOV:  res_data = op_a;
            default: begin
                res_illegal = 1'b1;
                res_write   = 1'b0;
            end
        endcase
        if (res_write) begin
            res_zero = (res_data == '0);
        end
    end

    // S1 loads a new instruction whenever it is free or emptying this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tgt   <= '0;
            s1_src0  <= '0;
            s1_src1  <= '0;
            s1_imm   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_op    <= in_op;
            s1_tgt   <= in_tgt;
            s1_src0  <= in_src0;
            s1_src1  <= in_src1;
            s1_imm   <= in_imm;
        end
    end

    // Register file write-back at execute; illegal ops and NOPs leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (exec_fire && res_write) begin
            regs[s1_tgt] <= res_data;
        end
    end

    // Output register: load on execute of a non-NOP, empty when consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_reg_id  <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (exec_fire && res_out) begin
            out_valid   <= 1'b1;
            out_data    <= res_data;
            out_reg_id  <= s1_tgt;
            out_carry   <= res_carry;
            out_zero    <= res_zero;
            out_illegal <= res_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of executed non-NOP instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (exec_fire && res_out && (retired_cnt != 16'hFFFF)) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_compute_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_param_compute_unit
//  Description : Self-checking bench: random instruction stream against an
//                arithmetic reference model, plus directed stall, reset and
//                16-bit / saturation scenarios on a second instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_compute_unit;

    localparam int W   = 8;
    localparam int NR  = 16;
    localparam int RW  = 4;
    localparam int BW  = 16;
    localparam int BNR = 4;
    localparam int BRW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (8-bit, 16 registers)
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_tgt, in_src0, in_src1, out_reg_id;
    logic [W-1:0]  in_imm, out_data;
    logic          out_carry, out_zero, out_illegal;
    logic [15:0]   retired_cnt;

    param_compute_unit #(.DATA_W(W), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_tgt(in_tgt), .in_src0(in_src0), .in_src1(in_src1), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_reg_id(out_reg_id), .out_carry(out_carry), .out_zero(out_zero),
        .out_illegal(out_illegal), .retired_cnt(retired_cnt)
    );

    // Second instance (16-bit, 4 registers)
    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]     b_in_op;
    logic [BRW-1:0] b_in_tgt, b_in_src0, b_in_src1, b_out_reg_id;
    logic [BW-1:0]  b_in_imm, b_out_data;
    logic           b_out_carry, b_out_zero, b_out_illegal;
    logic [15:0]    b_retired_cnt;

    param_compute_unit #(.DATA_W(BW), .NUM_REGS(BNR)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_tgt(b_in_tgt), .in_src0(b_in_src0), .in_src1(b_in_src1), .in_imm(b_in_imm),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_reg_id(b_out_reg_id), .out_carry(b_out_carry), .out_zero(b_out_zero),
        .out_illegal(b_out_illegal), .retired_cnt(b_retired_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [RW-1:0] id;
        logic [W-1:0]  data;
        logic          carry;
        logic          zero;
        logic          illegal;
    } res_t;

    res_t exp_q[$];
    int   mdl_regs [NR];
    int   mdl_retired = 0;

    // Sequential-semantics model: each instruction sees all earlier results
    task automatic model_exec(input int op, input int tgt, input int s0, input int s1, input int imm);
        int  a, b, r, mask;
        bit  c, ill;
        res_t e;
        mask = (1 << W) - 1;
        a = mdl_regs[s0];
        b = mdl_regs[s1];
        r = 0; c = 0; ill = 0;
        if (op == 0) return;
        case (op)
            1:  r = imm;
            2:  begin r = a + b; c = (r > mask); end
            3:  begin r = a - b; c = (a < b); end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = ~a;
            7:  r = a ^ b;
            8:  r = a << (b % W);
            9:  r = a >> (b % W);
            10: r = a;
            default: ill = 1;
        endcase
        r = r & mask;
        if (ill) r = 0;
        else mdl_regs[tgt] = r;
        if (mdl_retired < 65535) mdl_retired++;
        e.id      = RW'(tgt);
        e.data    = W'(r);
        e.carry   = c;
        e.zero    = !ill && (r == 0);
        e.illegal = ill;
        exp_q.push_back(e);
    endtask

    // Handshakes are stable at the falling edge; they take effect on the next rise
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_reg_id), 64'hDEAD);
                end else begin
                    res_t exp_r, got_r;
                    exp_r = exp_q.pop_front();
                    got_r = {out_reg_id, out_data, out_carry, out_zero, out_illegal};
                    check("result", 64'(got_r), 64'(exp_r));
                end
            end
            if (in_valid && in_ready) begin
                model_exec(int'(in_op), int'(in_tgt), int'(in_src0), int'(in_src1), int'(in_imm));
            end
        end
    end

    // Random back-pressure
    bit rand_ready = 0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int op, input int tgt, input int s0, input int s1, input int imm);
        int k = 0;
        in_valid = 1'b1;
        in_op    = 4'(op);
        in_tgt   = RW'(tgt);
        in_src0  = RW'(s0);
        in_src1  = RW'(s1);
        in_imm   = W'(imm);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("retired_cnt", 64'(retired_cnt), 64'(mdl_retired));
    endtask

    task automatic bsend(input int op, input int tgt, input int s0, input int s1, input int imm);
        int k = 0;
        b_in_valid = 1'b1;
        b_in_op    = 4'(op);
        b_in_tgt   = BRW'(tgt);
        b_in_src0  = BRW'(s0);
        b_in_src1  = BRW'(s1);
        b_in_imm   = BW'(imm);
        forever begin
            @(negedge clk);
            if (b_in_ready) break;
            k++;
            if (k > 200) begin
                check("bsend_timeout", 64'(b_in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hard stop if anything hangs
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] held;
        int           accepted;
        int           idx;
        int           k;

        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_tgt = '0; in_src0 = '0; in_src1 = '0; in_imm = '0;
        out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_op = '0; b_in_tgt = '0; b_in_src0 = '0; b_in_src1 = '0;
        b_in_imm = '0; b_out_ready = 1'b1;
        for (int i = 0; i < NR; i++) mdl_regs[i] = 0;

        #2;
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_out_data",  64'(out_data),    64'd0);
        check("rst_flags",     64'({out_carry, out_zero, out_illegal, out_reg_id}), 64'd0);
        check("rst_retired",   64'(retired_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Load, load, dependent add with carry out
        send(1, 1, 0, 0, 8'hF0);
        send(1, 2, 0, 0, 8'h20);
        send(2, 3, 1, 2, 0);
        drain();

        // Self-subtract to zero, then borrow from r0
        send(1, 4, 0, 0, 8'h05);
        send(3, 5, 4, 4, 0);
        send(3, 6, 0, 4, 0);
        drain();

        // NOP produces nothing; 0xC is illegal and must not touch r1
        send(0, 1, 2, 3, 8'h77);
        send(12, 1, 2, 3, 8'h77);
        send(10, 7, 1, 0, 0);
        drain();

        // Back-pressure: three offers while the consumer stalls
        out_ready = 1'b0;
        accepted  = 0;
        idx       = 0;
        held      = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 3);
            in_op    = 4'h1;
            in_tgt   = RW'(9 + idx);
            in_src0  = '0;
            in_src1  = '0;
            in_imm   = W'(8'h11 * (idx + 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                accepted++;
                idx++;
            end
            if (cyc == 2) held = out_data;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_accepts",   64'(accepted),  64'd2);
        check("stall_in_ready",  64'(in_ready),  64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_data",  64'(out_data),  64'(held));
        @(posedge clk); #1;
        out_ready = 1'b1;
        k = 0;
        while (idx < 3 && k < 50) begin
            in_valid = 1'b1;
            in_op    = 4'h1;
            in_tgt   = RW'(9 + idx);
            in_imm   = W'(8'h11 * (idx + 1));
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            k++;
        end
        drain();

        // Random stream with random back-pressure
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            send($urandom_range(0, 15), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                 $urandom_range(0, NR - 1), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 0;
        @(posedge clk); #2;
        drain();

        // Reset while S1 and the output register both hold instructions
        out_ready = 1'b0;
        send(1, 7, 0, 0, 8'h55);
        send(1, 8, 0, 0, 8'h66);
        #2;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NR; i++) mdl_regs[i] = 0;
        mdl_retired = 0;
        #1;
        check("midrst_out_valid", 64'(out_valid),   64'd0);
        check("midrst_out_data",  64'(out_data),    64'd0);
        check("midrst_out_id",    64'(out_reg_id),  64'd0);
        check("midrst_retired",   64'(retired_cnt), 64'd0);
        check("midrst_in_ready",  64'(in_ready),    64'd1);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(10, 12, 7, 0, 0);
        send(10, 13, 8, 0, 0);
        drain();

        // 16-bit instance: shift amount wraps modulo width
        bsend(1, 1, 0, 0, 16'h8001);
        bsend(1, 2, 0, 0, 17);
        bsend(8, 3, 1, 2, 0);
        b_in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(b_out_valid && b_out_reg_id == 2'd3) && k < 20);
        check("b_shl_data",  64'(b_out_data), 64'h0002);
        check("b_shl_flags", 64'({b_out_carry, b_out_zero, b_out_illegal}), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("b_retired_3", 64'(b_retired_cnt), 64'd3);

        // Push the counter past its ceiling
        for (int n = 0; n < 65537; n++) begin
            bsend(1, n % BNR, 0, 0, n);
        end
        b_in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("b_retired_sat", 64'(b_retired_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
